// File: rtl/multi_blinker_if.sv
// Config/status bundle for multi_blinker: channel config strobe, global sync, LED levels.
// Latency: n/a (wires only); the slave registers everything it drives.
// Backpressure: none; the slave accepts a config write or sync on every cycle.
// Ports (slave view): cfg_we/cfg_ch/cfg_mode/cfg_half/sync in; out/cfg_err out.
interface multi_blinker_if #(
   parameter int CHANNELS = 8,
   parameter int CNT_W    = 32
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                cfg_we;
   logic [CH_W-1:0]     cfg_ch;
   logic [1:0]          cfg_mode;
   logic [CNT_W-1:0]    cfg_half;
   logic                sync;
   logic [CHANNELS-1:0] out;
   logic                cfg_err;

   modport master (
      output cfg_we, cfg_ch, cfg_mode, cfg_half, sync,
      input  out, cfg_err
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_mode, cfg_half, sync,
      output out, cfg_err
   );
endinterface

// File: rtl/multi_blinker.sv
// N-channel LED pattern generator: per-channel off / on / blink / one-shot pulse.
// Latency: a config write or sync is visible on out the cycle after the strobe.
// Backpressure: none; writes and sync are accepted every cycle, bad channel -> cfg_err.
// Ports: clk, rst_n (async, active-low); bus (multi_blinker_if.slave) carries
//   cfg_we/cfg_ch/cfg_mode/cfg_half/sync in and registered out/cfg_err.
module multi_blinker #(
   parameter int CHANNELS = 8,
   parameter int CNT_W    = 32,
   parameter int DEF_HALF = 25_000_000
) (
   input logic             clk,
   input logic             rst_n,
   multi_blinker_if.slave  bus
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   // One extra bit so CHANNELS itself is representable for the range check.
   localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PULSE = 2'b11
   } mode_t;

   mode_t               mode_q [CHANNELS];
   mode_t               mode_d [CHANNELS];
   logic [CNT_W-1:0]    half_q [CHANNELS];
   logic [CNT_W-1:0]    half_d [CHANNELS];
   logic [CNT_W-1:0]    cnt_q  [CHANNELS];
   logic [CNT_W-1:0]    cnt_d  [CHANNELS];
   logic [CHANNELS-1:0] lvl_q, lvl_d;
   logic [CHANNELS-1:0] done_q, done_d;
   logic [CHANNELS-1:0] wr_sel;
   logic                cfg_ok;
   logic                cfg_err_q, cfg_err_d;

   // Last count value of a level: heff-1, with half==0 behaving as half==1.
   // Working on heff-1 avoids any overflow when half is all ones.
   function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] half);
      return (half == '0) ? '0 : half - CNT_W'(1);
   endfunction

   assign cfg_ok    = ({1'b0, bus.cfg_ch} < CH_LIMIT);
   assign cfg_err_d = bus.cfg_we && !cfg_ok;

   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_sel[i] = bus.cfg_we && cfg_ok && (bus.cfg_ch == CH_W'(i));
      end
   end

   always_comb begin
      lvl_d  = lvl_q;
      done_d = done_q;
      for (int i = 0; i < CHANNELS; i++) begin
         mode_d[i] = mode_q[i];
         half_d[i] = half_q[i];
         cnt_d[i]  = cnt_q[i];

         case (mode_q[i])
            MODE_OFF: begin
               lvl_d[i] = 1'b0;
               cnt_d[i] = '0;
            end
            MODE_ON: begin
               lvl_d[i] = 1'b1;
               cnt_d[i] = '0;
            end
            MODE_BLINK: begin
               // >= rather than == so a freshly shortened half cannot run away.
               if (cnt_q[i] >= last_cnt(half_q[i])) begin
                  lvl_d[i] = ~lvl_q[i];
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            MODE_PULSE: begin
               if (done_q[i]) begin
                  lvl_d[i] = 1'b0;
                  cnt_d[i] = '0;
               end else if (cnt_q[i] >= last_cnt(half_q[i])) begin
                  lvl_d[i]  = 1'b0;
                  done_d[i] = 1'b1;
                  cnt_d[i]  = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
         endcase

         // Sync and a write restart a channel identically, so the write simply
         // overrides with the new mode/half when both land on the same cycle.
         if (bus.sync) begin
            cnt_d[i]  = '0;
            lvl_d[i]  = (mode_q[i] != MODE_OFF);
            done_d[i] = 1'b0;
         end
         if (wr_sel[i]) begin
            mode_d[i] = mode_t'(bus.cfg_mode);
            half_d[i] = bus.cfg_half;
            cnt_d[i]  = '0;
            lvl_d[i]  = (bus.cfg_mode != MODE_OFF);
            done_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i] <= MODE_BLINK;
            half_q[i] <= CNT_W'(DEF_HALF);
            cnt_q[i]  <= '0;
         end
         lvl_q     <= '1;
         done_q    <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i] <= mode_d[i];
            half_q[i] <= half_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         lvl_q     <= lvl_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign bus.out     = lvl_q;
   assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_multi_blinker.sv
// Self-checking bench for multi_blinker: directed scenarios then random config/sync traffic.
// Reference model tracks, per channel, mode, half and cycles elapsed since last restart,
// and derives the LED level arithmetically from those.
module tb_multi_blinker;
   localparam int CH   = 6;
   localparam int CW   = 8;
   localparam int DEFH = 4;
   localparam int CHW  = $clog2(CH);

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   multi_blinker_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

   multi_blinker #(
      .CHANNELS (CH),
      .CNT_W    (CW),
      .DEF_HALF (DEFH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: mode, programmed half, cycles since last restart.
   int   m_mode [CH];
   int   m_half [CH];
   int   m_age  [CH];
   logic m_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_lvl(input int md, input int half, input int age);
      int heff;
      heff = (half == 0) ? 1 : half;
      case (md)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return ((age / heff) % 2) == 0;
         default: return age < heff;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_mode[i] = 2;
         m_half[i] = DEFH;
         m_age[i]  = 0;
      end
      m_err = 1'b0;
   endtask

   // Called just after a rising edge, with the inputs that edge sampled.
   task automatic model_edge();
      logic wr_ok;
      wr_ok = bus.cfg_we && (int'(bus.cfg_ch) < CH);
      for (int i = 0; i < CH; i++) begin
         if (wr_ok && int'(bus.cfg_ch) == i) begin
            m_mode[i] = int'(bus.cfg_mode);
            m_half[i] = int'(bus.cfg_half);
            m_age[i]  = 0;
         end else if (bus.sync) begin
            m_age[i] = 0;
         end else begin
            m_age[i]++;
         end
      end
      m_err = bus.cfg_we && !wr_ok;
   endtask

   task automatic compare();
      logic [CH-1:0] e;
      for (int i = 0; i < CH; i++) e[i] = model_lvl(m_mode[i], m_half[i], m_age[i]);
      check("out", 64'(bus.out), 64'(e));
      check("cfg_err", 64'(bus.cfg_err), 64'(m_err));
   endtask

   // Inputs are driven at the falling edge, sampled by the DUT at the next rising edge.
   task automatic step(input logic we, input int ch, input int md, input int hf, input logic sy);
      bus.cfg_we   = we;
      bus.cfg_ch   = CHW'(ch);
      bus.cfg_mode = 2'(md);
      bus.cfg_half = CW'(hf);
      bus.sync     = sy;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic wr(input int ch, input int md, input int hf);
      step(1'b1, ch, md, hf, 1'b0);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.cfg_we   = 1'b0;
      bus.cfg_ch   = '0;
      bus.cfg_mode = '0;
      bus.cfg_half = '0;
      bus.sync     = 1'b0;
      model_reset();

      // Reset state, held across a couple of edges.
      repeat (2) @(negedge clk);
      check("rst_out", 64'(bus.out), 64'({CH{1'b1}}));
      check("rst_err", 64'(bus.cfg_err), 64'd0);
      rst_n = 1'b1;

      // All channels blink together with DEF_HALF-cycle levels.
      compare();
      idle(12);

      // Blink write with a short half; others keep their phase.
      wr(2, 2, 2);
      idle(12);

      // Static off, then on.
      wr(1, 0, 9);
      idle(22);
      wr(1, 1, 9);
      idle(10);

      // One-shot pulse, retrigger by sync, then zero-half pulse.
      wr(3, 3, 5);
      idle(10);
      step(1'b0, 0, 0, 0, 1'b1);
      idle(8);
      wr(3, 3, 0);
      idle(4);

      // Shrink a running half mid-level, then sync coincident with a write.
      wr(0, 2, 10);
      idle(7);
      wr(0, 2, 3);
      idle(10);
      step(1'b1, 1, 2, 3, 1'b1);
      idle(5);

      // Out-of-range channel writes, alone and with sync.
      wr(7, 0, 1);
      idle(2);
      wr(6, 1, 1);
      step(1'b1, 7, 0, 0, 1'b1);
      idle(3);

      // Largest legal half.
      wr(4, 2, (1 << CW) - 1);
      idle(600);
      wr(5, 3, (1 << CW) - 1);
      idle(300);

      // Asynchronous reset in the middle of a blink level.
      wr(0, 2, 6);
      idle(3);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out", 64'(bus.out), 64'({CH{1'b1}}));
      check("async_rst_err", 64'(bus.cfg_err), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      compare();
      idle(10);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         logic we, sy;
         int   hf;
         we = ($urandom_range(0, 7) == 0);
         sy = ($urandom_range(0, 39) == 0);
         hf = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, (1 << CW) - 1))
                                           : int'($urandom_range(0, 12));
         step(we, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), hf, sy);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
